// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects four pushbuttons into one-hot command pulses.
// Optional AUTO_REPEAT_EN adds hold-to-repeat on up/down.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_set9,
    input  logic       btn_set0,
    output logic       up,
    output logic       down,
    output logic       set9,
    output logic       set0,
    output logic [3:0] btn_level
);
    localparam int unsigned NCH  = 4;
    localparam int unsigned M1   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAXC = (M1 > REPEAT_PERIOD) ? M1 : REPEAT_PERIOD;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
`ifdef AUTO_REPEAT_EN
    localparam logic [1:0] ST_DELAY   = 2'd2;
    localparam logic [1:0] ST_REPEAT  = 2'd3;
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [NCH-1:0] REP_MASK = 4'b0011;
`endif

    // Channel order matches btn_level: {set0, set9, down, up}
    logic [NCH-1:0] raw;
    logic [NCH-1:0] s0, s1;
    logic [NCH-1:0] level, level_d;
    logic [CW-1:0]  cnt   [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [1:0]     state   [NCH];
    logic [1:0]     state_d [NCH];
`ifdef AUTO_REPEAT_EN
    logic [CW-1:0]  tmr   [NCH];
    logic [CW-1:0]  tmr_d [NCH];
`endif
    logic [NCH-1:0] req;
    logic [NCH-1:0] grant;

    assign raw       = {btn_set0, btn_set9, btn_down, btn_up};
    assign btn_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0    <= '0;
            s1    <= '0;
            level <= '0;
            {set0, set9, down, up} <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]   <= '0;
                state[i] <= ST_IDLE;
`ifdef AUTO_REPEAT_EN
                tmr[i]   <= '0;
`endif
            end
        end else begin
            s0    <= raw;
            s1    <= s0;
            level <= level_d;
            {set0, set9, down, up} <= grant;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]   <= cnt_d[i];
                state[i] <= state_d[i];
`ifdef AUTO_REPEAT_EN
                tmr[i]   <= tmr_d[i];
`endif
            end
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        level_d = level;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt[i];
            if (s1[i] == level[i]) begin
                cnt_d[i] = '0;
            end else if (cnt[i] == DB_LAST) begin
                level_d[i] = s1[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt[i] + CW'(1);
            end
        end
    end

    // Press FSM: requests are raised on the same edge the debounced level rises
    always_comb begin
        req = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state[i];
`ifdef AUTO_REPEAT_EN
            tmr_d[i]   = tmr[i];
`endif
            case (state[i])
                ST_IDLE: begin
                    if (level_d[i]) begin
                        req[i]     = 1'b1;
                        state_d[i] = ST_PRESSED;
`ifdef AUTO_REPEAT_EN
                        if (REP_MASK[i]) state_d[i] = ST_DELAY;
                        tmr_d[i] = '0;
`endif
                    end
                end
                ST_PRESSED: begin
                    if (!level_d[i]) state_d[i] = ST_IDLE;
                end
`ifdef AUTO_REPEAT_EN
                ST_DELAY, ST_REPEAT: begin
                    if (!level_d[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (tmr[i] == ((state[i] == ST_DELAY) ? RD_LAST : RP_LAST)) begin
                        req[i]     = 1'b1;
                        state_d[i] = ST_REPEAT;
                        tmr_d[i]   = '0;
                    end else begin
                        tmr_d[i] = tmr[i] + CW'(1);
                    end
                end
`endif
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Fixed priority set0 > set9 > up > down; losers are dropped
    always_comb begin
        grant = '0;
        if (req[3])      grant = 4'b1000;
        else if (req[2]) grant = 4'b0100;
        else if (req[0]) grant = 4'b0001;
        else if (req[1]) grant = 4'b0010;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: window-based debounce model plus directed press scenarios.
module tb_button_conditioner;
    localparam int DC = 4;
    localparam int RD = 50;
    localparam int RP = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_set9 = 1'b0, btn_set0 = 1'b0;
    logic up, down, set9, set0;
    logic [3:0] btn_level;

    button_conditioner #(.DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_set9(btn_set9), .btn_set0(btn_set0),
        .up(up), .down(down), .set9(set9), .set0(set0),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    task automatic check(input string name, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Model: level flips when the last DC synchronised samples (raw delayed 2 edges) all disagree
    logic [3:0] hist [$];
    logic [3:0] m_level = '0;
    logic [3:0] m_out = '0;
    logic [3:0] m_new, m_req;
    int         age [4];
    bit         all_diff;
    int         idx;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hist.delete();
            repeat (DC + 2) hist.push_back(4'b0000);
            m_level = '0;
            m_out   = '0;
            for (int c = 0; c < 4; c++) age[c] = 0;
        end else begin
            hist.push_back({btn_set0, btn_set9, btn_down, btn_up});
            void'(hist.pop_front());
            m_req = '0;
            for (int c = 0; c < 4; c++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    idx = hist.size() - 3 - j;
                    if (hist[idx][c] == m_level[c]) all_diff = 1'b0;
                end
                m_new[c] = all_diff ? ~m_level[c] : m_level[c];
                if (!m_level[c] && m_new[c]) begin
                    m_req[c] = 1'b1;
                    age[c] = 0;
                end else if (m_level[c] && m_new[c]) begin
                    age[c]++;
`ifdef AUTO_REPEAT_EN
                    if (c < 2 && (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0)))
                        m_req[c] = 1'b1;
`endif
                end
            end
            m_out = m_req[3] ? 4'b1000 : m_req[2] ? 4'b0100 :
                    m_req[0] ? 4'b0001 : m_req[1] ? 4'b0010 : 4'b0000;
            m_level = m_new;
        end
    end

    // Pulse logs (cycle numbers) used by the hand-computed scenario checks
    int up_q[$], down_q[$], set9_q[$], set0_q[$];

    always @(negedge clk) begin
        check("outputs", {24'd0, set0, set9, down, up, btn_level}, {24'd0, m_out, m_level});
        if (up)   up_q.push_back(cyc);
        if (down) down_q.push_back(cyc);
        if (set9) set9_q.push_back(cyc);
        if (set0) set0_q.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int p, bu, bd, b9, b0;

    task automatic snap();
        bu = up_q.size(); bd = down_q.size(); b9 = set9_q.size(); b0 = set0_q.size();
    endtask

    initial begin
        tick(3);
        check("reset_outs", {27'd0, set0, set9, down, up, btn_level[0]}, 0);
        check("reset_level", {28'd0, btn_level}, 0);
        rst = 1'b0;
        tick(3);

        // 1: clean press
        snap();
        btn_up = 1'b1; p = cyc;
        tick(20);
        check("t1_up_count", up_q.size() - bu, 1);
        if (up_q.size() > bu) check("t1_latency", up_q[bu] - p, 6);
        check("t1_level", {28'd0, btn_level}, 1);
        check("t1_others", down_q.size() + set9_q.size() + set0_q.size() - bd - b9 - b0, 0);
        btn_up = 1'b0;
        tick(10);

        // 2: bounce
        snap();
        btn_down = 1'b1; tick(1);
        btn_down = 1'b0; tick(1);
        btn_down = 1'b1; tick(1);
        btn_down = 1'b0; tick(1);
        btn_down = 1'b1; p = cyc;
        tick(20);
        check("t2_down_count", down_q.size() - bd, 1);
        if (down_q.size() > bd) check("t2_latency", down_q[bd] - p, 6);
        btn_down = 1'b0;
        tick(10);

        // 3: simultaneous set0 and up
        snap();
        btn_set0 = 1'b1; btn_up = 1'b1;
        tick(20);
        check("t3_set0_count", set0_q.size() - b0, 1);
        check("t3_up_count", up_q.size() - bu, 0);
        check("t3_level", {28'd0, btn_level}, 9);
        btn_set0 = 1'b0; btn_up = 1'b0;
        tick(10);

        // 4: reset mid-debounce with set9 held
        snap();
        btn_set9 = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(3);
        check("t4_in_reset", {27'd0, set0, set9, down, up, |btn_level}, 0);
        rst = 1'b0; p = cyc;
        tick(15);
        check("t4_set9_count", set9_q.size() - b9, 1);
        if (set9_q.size() > b9) check("t4_latency", set9_q[b9] - p, 6);
        btn_set9 = 1'b0;
        tick(10);

        // 5: release / re-press, then a short low glitch while held
        snap();
        btn_up = 1'b1; tick(10);
        btn_up = 1'b0; tick(10);
        btn_up = 1'b1; tick(10);
        btn_up = 1'b0; tick(10);
        check("t5_two_presses", up_q.size() - bu, 2);
        snap();
        btn_up = 1'b1; tick(10);
        btn_up = 1'b0; tick(2);
        btn_up = 1'b1; tick(10);
        btn_up = 1'b0; tick(10);
        check("t5_glitch", up_q.size() - bu, 1);

`ifdef AUTO_REPEAT_EN
        // 6: auto-repeat on up, none on set0
        begin
            int exp_d [6] = '{6, 56, 66, 76, 86, 96};
            snap();
            btn_up = 1'b1; p = cyc;
            tick(100);
            btn_up = 1'b0;
            tick(10);
            check("t6_up_count", up_q.size() - bu, 6);
            for (int k = 0; k < 6; k++)
                if (up_q.size() > bu + k) check("t6_up_time", up_q[bu + k] - p, exp_d[k]);
            btn_set0 = 1'b1;
            tick(100);
            btn_set0 = 1'b0;
            tick(10);
            check("t6_set0_count", set0_q.size() - b0, 1);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
